risc16_fetch_queue: RTL and testbench

Instruction fetch front end for the 16-bit RISC core. Owns the fetch PC, issues reads to the synchronous instruction memory (1-cycle read latency), and buffers returned instructions with their PCs in a small prefetch FIFO. It feeds the core's decode stage through a valid/ready handshake. Branch and jump redirects from the core flush the queue and restart fetch at the new PC.

---
 rtl/risc16_fetch_queue_pkg.sv | 28 ++
 rtl/risc16_fetch_queue_sync_fifo.sv | 77 +++++++
 rtl/risc16_fetch_queue.sv | 87 ++++++++
 tb/tb_risc16_fetch_queue.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/risc16_fetch_queue_pkg.sv
// Shared widths, fetch entry layout and PC helpers for the RISC16 fetch front end.
package risc16_fetch_queue_pkg;

    localparam int INST_W = 16;
    localparam int PC_W   = 16;

    localparam logic [PC_W-1:0] PC_STEP          = 16'd2;
    localparam logic [PC_W-1:0] DEFAULT_RESET_PC = 16'h0000;

    // One prefetched instruction together with the address it was fetched from.
    typedef struct packed {
        logic [PC_W-1:0]   pc;
        logic [INST_W-1:0] inst;
    } fetch_entry_t;

    localparam int ENTRY_W = $bits(fetch_entry_t);

    // Instructions are halfword aligned; bit 0 of any incoming PC is dropped.
    function automatic logic [PC_W-1:0] align_pc(input logic [PC_W-1:0] pc);
        return {pc[PC_W-1:1], 1'b0};
    endfunction

    // Sequential fetch address; wraps naturally modulo 2^16.
    function automatic logic [PC_W-1:0] next_pc(input logic [PC_W-1:0] pc);
        return pc + PC_STEP;
    endfunction

endpackage

// File: rtl/risc16_fetch_queue_sync_fifo.sv
// Small synchronous FIFO with flush and a registered head, so the consumer
// sees head data and valid straight from flops.
module risc16_sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic                       head_valid,
    output logic [WIDTH-1:0]           head_data,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count_q;

    logic             pop_eff;
    logic             push_eff;
    logic [CNT_W-1:0] count_after_pop;
    logic [CNT_W-1:0] count_nxt;
    logic [PTR_W-1:0] rd_ptr_nxt;
    logic [PTR_W-1:0] wr_ptr_nxt;
    logic [WIDTH-1:0] head_nxt;

    // Next pointers, occupancy and the value the head register will hold.
    always_comb begin
        pop_eff         = pop && (count_q != '0);
        count_after_pop = count_q - CNT_W'(pop_eff);
        push_eff        = push && (count_after_pop < CNT_W'(DEPTH));
        count_nxt       = count_after_pop + CNT_W'(push_eff);
        rd_ptr_nxt      = rd_ptr + PTR_W'(pop_eff);
        wr_ptr_nxt      = wr_ptr + PTR_W'(push_eff);
        head_nxt        = '0;
        if (count_after_pop != '0) begin
            head_nxt = mem[rd_ptr_nxt];
        end else if (push_eff) begin
            // Pushing into an empty queue: the new word goes straight to the head.
            head_nxt = push_data;
        end
    end

    // Pointer, count and head registers; flush empties the queue and wins over push/pop.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count_q    <= '0;
            head_valid <= 1'b0;
            head_data  <= '0;
        end else begin
            rd_ptr     <= rd_ptr_nxt;
            wr_ptr     <= wr_ptr_nxt;
            count_q    <= count_nxt;
            head_valid <= (count_nxt != '0);
            head_data  <= head_nxt;
        end
    end

    // Storage array; contents need no reset because validity lives in count.
    always_ff @(posedge clk) begin
        if (push_eff && !flush && !reset) begin
            mem[wr_ptr] <= push_data;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/risc16_fetch_queue.sv
// Fetch front end: owns the fetch PC, issues reads to the 1-cycle instruction
// memory and buffers returned words with their PCs for the decode stage.
module risc16_fetch_queue
    import risc16_fetch_queue_pkg::*;
#(
    parameter int              DEPTH    = 4,
    parameter logic [PC_W-1:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic              clk,
    input  logic              reset,
    output logic              imem_en,
    output logic [PC_W-1:0]   imem_addr,
    input  logic [INST_W-1:0] imem_rdata,
    input  logic              redirect_valid,
    input  logic [PC_W-1:0]   redirect_pc,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [INST_W-1:0] inst_data,
    output logic [PC_W-1:0]   inst_pc
);

    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [PC_W-1:0]  fetch_pc;
    logic [PC_W-1:0]  issued_pc;
    logic             inflight;
    logic             kill;
    logic [CNT_W-1:0] fifo_count;
    logic [CNT_W:0]   occupancy;
    logic             issue;
    logic             push;
    fetch_entry_t     push_entry;
    fetch_entry_t     head_entry;
    logic             head_valid;

    // Issue only while a FIFO slot is still free counting the read already in flight.
    always_comb begin
        occupancy  = {1'b0, fifo_count} + (CNT_W + 1)'(inflight);
        issue      = !reset && !redirect_valid && (occupancy < (CNT_W + 1)'(DEPTH));
        push       = inflight && !kill;
        push_entry = '{pc: issued_pc, inst: imem_rdata};
    end

    // Fetch PC and in-flight tracking; redirect restarts the stream at the new PC.
    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc  <= RESET_PC;
            issued_pc <= RESET_PC;
            inflight  <= 1'b0;
            kill      <= 1'b0;
        end else if (redirect_valid) begin
            fetch_pc <= align_pc(redirect_pc);
            inflight <= 1'b0;
            // Whatever is still on its way belongs to the old stream.
            kill     <= inflight;
        end else begin
            kill     <= 1'b0;
            inflight <= issue;
            if (issue) begin
                issued_pc <= fetch_pc;
                fetch_pc  <= next_pc(fetch_pc);
            end
        end
    end

    risc16_sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .flush      (redirect_valid),
        .push       (push),
        .push_data  (push_entry),
        .pop        (inst_ready),
        .head_valid (head_valid),
        .head_data  (head_entry),
        .count      (fifo_count)
    );

    assign imem_en    = issue;
    assign imem_addr  = fetch_pc;
    assign inst_valid = head_valid;
    assign inst_data  = head_entry.inst;
    assign inst_pc    = head_entry.pc;

endmodule

// File: tb/tb_risc16_fetch_queue.sv
// Self-checking bench for risc16_fetch_queue: directed scenarios plus a random
// phase, all compared cycle by cycle with a queue-based reference model.
module tb_risc16_fetch_queue;

    localparam int          DEPTH    = 4;
    localparam logic [15:0] RESET_PC = 16'h0000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        imem_en;
    logic [15:0] imem_addr;
    logic [15:0] imem_rdata = 16'h0000;
    logic        redirect_valid = 1'b0;
    logic [15:0] redirect_pc = 16'h0000;
    logic        inst_valid;
    logic        inst_ready = 1'b0;
    logic [15:0] inst_data;
    logic [15:0] inst_pc;

    always #5 clk = ~clk;

    risc16_fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk            (clk),
        .reset          (reset),
        .imem_en        (imem_en),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst_data      (inst_data),
        .inst_pc        (inst_pc)
    );

    // Instruction memory: word = addr ^ key, one cycle read latency.
    logic [15:0] key = 16'h0000;
    always @(posedge clk) if (imem_en) imem_rdata <= imem_addr ^ key;

    // Reference model: list of buffered {pc, inst}, one pending read, next PC.
    typedef struct { logic [15:0] pc; logic [15:0] inst; } ent_t;
    ent_t        q[$];
    bit          pend = 0;
    logic [15:0] pend_pc, pend_inst;
    logic [15:0] fpc = RESET_PC;
    bit          known = 0;

    int total = 0;
    int bad = 0;

    bit          obs_en, obs_valid;
    logic [15:0] obs_addr, obs_pc, obs_data;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input bit rst, input bit redir, input logic [15:0] rpc, input bit rdy);
        bit exp_en;
        bit pop;
        reset = rst; redirect_valid = redir; redirect_pc = rpc; inst_ready = rdy;
        @(negedge clk);
        exp_en = !rst && !redir && known && ((q.size() + int'(pend)) < DEPTH);
        obs_en = imem_en; obs_addr = imem_addr; obs_valid = inst_valid;
        obs_pc = inst_pc; obs_data = inst_data;
        chk("imem_en", 32'(imem_en), 32'(exp_en));
        if (known) begin
            chk("imem_addr", 32'(imem_addr), 32'(fpc));
            chk("inst_valid", 32'(inst_valid), 32'(q.size() != 0));
            if (q.size() != 0) begin
                chk("inst_pc", 32'(inst_pc), 32'(q[0].pc));
                chk("inst_data", 32'(inst_data), 32'(q[0].inst));
            end
        end
        pop = (q.size() != 0) && rdy;
        @(posedge clk);
        if (rst) begin
            q.delete(); pend = 0; fpc = RESET_PC; known = 1;
        end else if (redir) begin
            q.delete(); pend = 0; fpc = {rpc[15:1], 1'b0};
        end else begin
            if (pop) void'(q.pop_front());
            if (pend) q.push_back('{pend_pc, pend_inst});
            pend = exp_en;
            if (exp_en) begin
                pend_pc = fpc; pend_inst = fpc ^ key; fpc = fpc + 16'd2;
            end
        end
        #1;
    endtask

    initial begin
        int issues;
        int r;
        bit saw_100;
        logic [15:0] pcs[4];

        // Reset, then free run with inst_ready=1.
        step(1, 0, 0, 1);
        step(1, 0, 0, 1);
        chk("rst_valid", 32'(obs_valid), 32'd0);
        chk("rst_data", 32'(obs_data), 32'd0);
        chk("rst_pc", 32'(obs_pc), 32'd0);
        chk("rst_en", 32'(obs_en), 32'd0);
        step(0, 0, 0, 1);
        chk("t0_en", 32'(obs_en), 32'd1);
        chk("t0_addr", 32'(obs_addr), 32'h0000);
        step(0, 0, 0, 1);
        step(0, 0, 0, 1);
        chk("t2_valid", 32'(obs_valid), 32'd1);
        chk("t2_pc", 32'(obs_pc), 32'h0000);
        step(0, 0, 0, 1);
        step(0, 0, 0, 1);
        step(0, 0, 0, 1);
        chk("t5_pc", 32'(obs_pc), 32'h0006);
        chk("t5_data", 32'(obs_data), 32'h0006);
        for (int i = 0; i < 6; i++) step(0, 0, 0, 1);

        // Backpressure from T0: exactly DEPTH issues, resume after first pop.
        step(1, 0, 0, 0);
        issues = 0;
        for (int i = 0; i < 8; i++) begin
            step(0, 0, 0, 0);
            if (obs_en) issues++;
        end
        chk("bp_issues", 32'(issues), 32'(DEPTH));
        chk("bp_full_valid", 32'(obs_valid), 32'd1);
        step(0, 0, 0, 1);
        chk("bp_pop_cycle_en", 32'(obs_en), 32'd0);
        step(0, 0, 0, 1);
        chk("bp_resume_en", 32'(obs_en), 32'd1);
        chk("bp_resume_addr", 32'(obs_addr), 32'h0008);
        for (int i = 0; i < 6; i++) step(0, 0, 0, 1);

        // Redirect to 0x0041 with count=3 and a read in flight.
        step(1, 0, 0, 0);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0);
        step(0, 1, 16'h0041, 0);
        step(0, 0, 0, 1);
        chk("rd_r1_valid", 32'(obs_valid), 32'd0);
        chk("rd_r1_addr", 32'(obs_addr), 32'h0040);
        step(0, 0, 0, 1);
        chk("rd_r2_valid", 32'(obs_valid), 32'd0);
        step(0, 0, 0, 1);
        chk("rd_r3_valid", 32'(obs_valid), 32'd1);
        chk("rd_r3_pc", 32'(obs_pc), 32'h0040);

        // PC wrap through 0xFFFE.
        step(0, 1, 16'hFFFC, 1);
        step(0, 0, 0, 1);
        step(0, 0, 0, 1);
        for (int i = 0; i < 4; i++) begin
            step(0, 0, 0, 1);
            pcs[i] = obs_pc;
        end
        chk("wrap0", 32'(pcs[0]), 32'hFFFC);
        chk("wrap1", 32'(pcs[1]), 32'hFFFE);
        chk("wrap2", 32'(pcs[2]), 32'h0000);
        chk("wrap3", 32'(pcs[3]), 32'h0002);

        // Back-to-back redirects: last one wins.
        step(0, 1, 16'h0100, 1);
        step(0, 1, 16'h0200, 1);
        saw_100 = 0;
        for (int i = 0; i < 6; i++) begin
            step(0, 0, 0, 1);
            if (obs_valid && obs_pc == 16'h0100) saw_100 = 1;
            if (i == 2) chk("b2b_first_pc", 32'(obs_pc), 32'h0200);
        end
        chk("b2b_no_0100", 32'(saw_100), 32'd0);

        // Reset pulse mid-stream with count=2.
        step(1, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0);
        step(1, 0, 0, 0);
        chk("mrst_en", 32'(obs_en), 32'd0);
        step(0, 0, 0, 1);
        chk("mrst_valid", 32'(obs_valid), 32'd0);
        chk("mrst_addr", 32'(obs_addr), 32'h0000);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 1);

        // Random phase against the model.
        key = 16'($urandom);
        for (int i = 0; i < 600; i++) begin
            r = int'($urandom_range(0, 99));
            if (i % 150 == 149) key = 16'($urandom);
            step(r == 0, (r >= 1 && r <= 6), 16'($urandom), $urandom_range(0, 3) != 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
